// File: rtl/lab4_net_bus_net_recv_vrtl.sv
// Bus network receiver.
// Terminates one bus output port. Accepted messages go into a 4-entry FIFO
// and are handed to the terminal in the order they arrived. The block also
// keeps a saturating per-source message count and a sticky flag that is set
// when a message arrives here that was addressed to another port.
//
// Ports:
//   clk, reset   - clock; asynchronous active-high reset
//   in_val/in_rdy/in_msg    - bus side, accept on in_val && in_rdy
//   out_val/out_rdy/out_msg - terminal side, dequeue on out_val && out_rdy
//   num_entries  - buffer occupancy, 0..4
//   src_count    - messages accepted per source (index = src field), saturate at 255
//   dest_err     - sticky: a message with dest != p_port_id was accepted
module lab4_net_bus_net_recv_vrtl #(
    parameter int p_msg_nbits = 44,
    parameter int p_port_id   = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_val,
    output logic                   in_rdy,
    input  logic [p_msg_nbits-1:0] in_msg,
    output logic                   out_val,
    input  logic                   out_rdy,
    output logic [p_msg_nbits-1:0] out_msg,
    output logic [2:0]             num_entries,
    output logic [3:0][7:0]        src_count,
    output logic                   dest_err
);

    localparam logic [1:0] port_id = p_port_id[1:0];

    logic [p_msg_nbits-1:0] buf_q [4];
    logic [1:0]             enq_ptr;
    logic [1:0]             deq_ptr;
    logic [2:0]             count;
    logic                   do_enq;
    logic                   do_deq;
    logic [1:0]             in_dest;
    logic [1:0]             in_src;

    assign in_dest = in_msg[p_msg_nbits-1 -: 2];
    assign in_src  = in_msg[p_msg_nbits-3 -: 2];

    // Handshake outputs come from registered state only, so there is no
    // combinational path from either side of the buffer to the other.
    assign in_rdy      = (count != 3'd4);
    assign out_val     = (count != 3'd0);
    assign out_msg     = buf_q[deq_ptr];
    assign num_entries = count;

    assign do_enq = in_val && in_rdy;
    assign do_deq = out_val && out_rdy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enq_ptr <= 2'd0;
            deq_ptr <= 2'd0;
            count   <= 3'd0;
        end else begin
            if (do_enq) enq_ptr <= enq_ptr + 2'd1;
            if (do_deq) deq_ptr <= deq_ptr + 2'd1;
            case ({do_enq, do_deq})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; the cleared count makes stale entries unreachable.
    always_ff @(posedge clk) begin
        if (do_enq) buf_q[enq_ptr] <= in_msg;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_count <= '0;
            dest_err  <= 1'b0;
        end else if (do_enq) begin
            if (src_count[in_src] != 8'hff)
                src_count[in_src] <= src_count[in_src] + 8'd1;
            if (in_dest != port_id)
                dest_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_lab4_net_bus_net_recv_vrtl.sv
// Scoreboard bench for the bus receiver (port id 2).
module tb_lab4_net_bus_net_recv_vrtl;

    localparam int NB = 44;
    localparam int PORT = 2;

    logic          clk;
    logic          reset;
    logic          in_val;
    logic          in_rdy;
    logic [NB-1:0] in_msg;
    logic          out_val;
    logic          out_rdy;
    logic [NB-1:0] out_msg;
    logic [2:0]    num_entries;
    logic [3:0][7:0] src_count;
    logic          dest_err;

    lab4_net_bus_net_recv_vrtl #(.p_msg_nbits(NB), .p_port_id(PORT)) dut (
        .clk(clk), .reset(reset),
        .in_val(in_val), .in_rdy(in_rdy), .in_msg(in_msg),
        .out_val(out_val), .out_rdy(out_rdy), .out_msg(out_msg),
        .num_entries(num_entries), .src_count(src_count), .dest_err(dest_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: the scoreboard queue holds exactly the messages the
    // receiver should currently be buffering, oldest first.
    logic [NB-1:0] sb[$];
    int  m_cnt[4];
    bit  m_err;
    int  n_pushed = 0;
    int  n_popped = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NB-1:0] mk(input int dest, input int src, input logic [31:0] pay);
        logic [7:0] opq;
        opq = 8'($urandom);
        return {dest[1:0], src[1:0], opq, pay};
    endfunction

    task automatic model_clear();
        sb.delete();
        for (int s = 0; s < 4; s++) m_cnt[s] = 0;
        m_err = 1'b0;
    endtask

    // Monitor/model: inputs are stable at the falling edge, so everything
    // that will happen at the next rising edge is decided here.
    always @(negedge clk) begin
        if (!reset) begin
            int occ;
            bit acc;
            occ = sb.size();
            acc = in_val && (occ < 4);
            chk("in_rdy", 64'(in_rdy), 64'(occ < 4));
            chk("out_val", 64'(out_val), 64'(occ > 0));
            chk("num_entries", 64'(num_entries), 64'(occ));
            for (int s = 0; s < 4; s++)
                chk($sformatf("src_count[%0d]", s), 64'(src_count[s]), 64'(m_cnt[s]));
            chk("dest_err", 64'(dest_err), 64'(m_err));
            if (occ > 0) begin
                chk("out_msg", 64'(out_msg), 64'(sb[0]));
                if (out_rdy) begin
                    void'(sb.pop_front());
                    n_popped++;
                end
            end
            if (acc) begin
                int s;
                sb.push_back(in_msg);
                n_pushed++;
                s = int'(in_msg[41:40]);
                m_cnt[s] = (m_cnt[s] + 1 > 255) ? 255 : m_cnt[s] + 1;
                if (int'(in_msg[43:42]) != PORT) m_err = 1'b1;
            end
        end
    end

    // One cycle of stimulus, applied just after the rising edge.
    task automatic drive(input logic v, input logic [NB-1:0] m, input logic ordy);
        @(posedge clk);
        #1;
        in_val  = v;
        in_msg  = m;
        out_rdy = ordy;
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (sb.size() > 0 && budget < 30) begin
            drive(1'b0, '0, 1'b1);
            budget++;
        end
        drive(1'b0, '0, 1'b0);
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        model_clear();
        reset   = 1'b0;
        in_val  = 1'b0;
        in_msg  = '0;
        out_rdy = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("rst_in_rdy", 64'(in_rdy), 64'd1);
        chk("rst_out_val", 64'(out_val), 64'd0);
        chk("rst_num_entries", 64'(num_entries), 64'd0);
        chk("rst_src_count", 64'(src_count), 64'd0);
        chk("rst_dest_err", 64'(dest_err), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b0;

        // single message
        drive(1'b1, mk(2, 1, 32'hDEADBEEF), 1'b1);
        drive(1'b0, '0, 1'b1);
        drain();

        // fill with terminal stalled; fifth message waits for a free slot
        for (int i = 0; i < 4; i++) drive(1'b1, mk(2, i, 32'(i)), 1'b0);
        drive(1'b1, mk(2, 0, 32'd4), 1'b0);
        drive(1'b1, mk(2, 0, 32'd4), 1'b0);
        drive(1'b1, mk(2, 0, 32'd4), 1'b1);
        drive(1'b1, mk(2, 0, 32'd4), 1'b1);
        drive(1'b0, '0, 1'b1);
        drain();

        // streaming, exercises pointer wrap
        for (int i = 0; i < 20; i++) drive(1'b1, mk(2, $urandom_range(0, 3), $urandom), 1'b1);
        drain();

        // random traffic with random backpressure and destinations
        for (int i = 0; i < 200; i++)
            drive(1'($urandom_range(0, 1)), mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom),
                  1'($urandom_range(0, 3) != 0));
        drain();

        // saturation and misrouted destinations from source 3
        for (int i = 0; i < 300; i++) drive(1'b1, mk(0, 3, 32'(i)), 1'b1);
        drain();
        chk("sat_src3", 64'(src_count[3]), 64'd255);
        chk("sat_dest_err", 64'(dest_err), 64'd1);

        // asynchronous reset with three entries buffered
        for (int i = 0; i < 3; i++) drive(1'b1, mk(1, 2, 32'hA000 + 32'(i)), 1'b0);
        @(posedge clk);
        #1 in_val = 1'b0;
        out_rdy = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("arst_out_val", 64'(out_val), 64'd0);
        chk("arst_num_entries", 64'(num_entries), 64'd0);
        chk("arst_in_rdy", 64'(in_rdy), 64'd1);
        chk("arst_src_count", 64'(src_count), 64'd0);
        chk("arst_dest_err", 64'(dest_err), 64'd0);
        n_popped += sb.size();
        model_clear();
        #1 reset = 1'b0;

        // post-reset traffic must not see pre-reset messages
        for (int i = 0; i < 3; i++) drive(1'b1, mk(2, 0, 32'hB000 + 32'(i)), 1'($urandom_range(0, 1)));
        drain();

        chk("pushed_vs_popped", 64'(n_popped), 64'(n_pushed));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
